// File: rtl/shmem_bank_arbiter.sv
// shmem_bank_arbiter: per-bank round-robin arbiters and ISSUE/WAIT sequencers
// sharing single-port shared-memory banks between requester load/store ports.
module shmem_bank_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_BANKS = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_write,
   input  logic [NUM_REQ*12-1:0]  req_addr,
   input  logic [NUM_REQ*8-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     req_err,
   output logic [NUM_REQ*8-1:0]   req_rdata,
   output logic [NUM_BANKS-1:0]   bank_read,
   output logic [NUM_BANKS-1:0]   bank_write,
   output logic [NUM_BANKS*8-1:0] bank_addr,
   output logic [NUM_BANKS*8-1:0] bank_data_in,
   input  logic [NUM_BANKS*8-1:0] bank_data_out,
   input  logic [NUM_BANKS-1:0]   bank_finish
);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int OW        = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t                 state_q [NUM_BANKS];
   state_t                 state_d [NUM_BANKS];
   logic [OW-1:0]          owner_q [NUM_BANKS];
   logic [OW-1:0]          owner_d [NUM_BANKS];
   logic [OW-1:0]          rr_q    [NUM_BANKS];
   logic [OW-1:0]          rr_d    [NUM_BANKS];
   logic [7:0]             cnt_q   [NUM_BANKS];
   logic [7:0]             cnt_d   [NUM_BANKS];
   logic [NUM_BANKS-1:0]   wr_q, wr_d, read_q, read_d, write_q, write_d;
   logic [NUM_BANKS*8-1:0] addr_q, addr_d, din_q, din_d;
   logic [NUM_REQ-1:0]     busy_q, busy_d, ack_q, ack_d, err_q, err_d;
   logic [NUM_REQ*8-1:0]   rdata_q, rdata_d;
   logic                   found;
   int                     idx;

   always_comb begin
      busy_d  = busy_q & ~ack_q;
      ack_d   = '0;
      err_d   = '0;
      rdata_d = '0;
      read_d  = '0;
      write_d = '0;
      addr_d  = addr_q;
      din_d   = din_q;
      wr_d    = wr_q;
      found   = 1'b0;
      idx     = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         state_d[b] = state_q[b];
         owner_d[b] = owner_q[b];
         rr_d[b]    = rr_q[b];
         cnt_d[b]   = cnt_q[b];
         case (state_q[b])
            IDLE: begin
               found = 1'b0;
               // circular search starting just after the last owner
               for (int k = 1; k <= NUM_REQ; k++) begin
                  idx = int'(rr_q[b]) + k;
                  idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
                  if (!found && req_valid[idx] && !busy_q[idx] &&
                      req_addr[idx*12 +: BANK_BITS] == BANK_BITS'(b)) begin
                     found            = 1'b1;
                     owner_d[b]       = OW'(idx);
                     busy_d[idx]      = 1'b1;
                     wr_d[b]          = req_write[idx];
                     read_d[b]        = !req_write[idx];
                     write_d[b]       = req_write[idx];
                     addr_d[b*8 +: 8] = req_addr[idx*12+4 +: 8];
                     din_d[b*8 +: 8]  = req_wdata[idx*8 +: 8];
                     state_d[b]       = ISSUE;
                  end
               end
            end
            ISSUE: begin
               state_d[b] = WAIT;
               cnt_d[b]   = '0;
            end
            WAIT: begin
               if (bank_finish[b] || cnt_q[b] == 8'(TIMEOUT-1)) begin
                  ack_d[owner_q[b]] = 1'b1;
                  err_d[owner_q[b]] = !bank_finish[b];
                  rdata_d[int'(owner_q[b])*8 +: 8] =
                     bank_finish[b] && !wr_q[b] ? bank_data_out[b*8 +: 8] : 8'h00;
                  rr_d[b]    = owner_q[b];
                  state_d[b] = IDLE;
               end else begin
                  cnt_d[b] = cnt_q[b] + 8'd1;
               end
            end
            default: state_d[b] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= IDLE;
            owner_q[b] <= '0;
            rr_q[b]    <= OW'(NUM_REQ-1);
            cnt_q[b]   <= '0;
         end
         wr_q    <= '0;
         read_q  <= '0;
         write_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         busy_q  <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         read_q  <= read_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign req_ack      = ack_q;
   assign req_err      = err_q;
   assign req_rdata    = rdata_q;
   assign bank_read    = read_q;
   assign bank_write   = write_q;
   assign bank_addr    = addr_q;
   assign bank_data_in = din_q;
endmodule
